// File: rtl/ahb_apb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_apb_pkg
// Shared definitions for the AHB-to-APB multi-completer bridge:
//   - HTRANS transfer-type encodings
//   - HRESP response codes
//   - bridge FSM state enumeration
//   - is_active_trans(): true for NONSEQ/SEQ transfers
// ---------------------------------------------------------------------------
package ahb_apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } bridge_state_e;

  // IDLE and BUSY carry no transfer; only NONSEQ/SEQ start one.
  function automatic logic is_active_trans(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/apb_slave_decoder.sv
// ---------------------------------------------------------------------------
// apb_slave_decoder
// Combinational completer decode: turns a binary region index into a one-hot
// PSEL vector, and flags whether the index maps to an existing completer.
// Ports:
//   index   in  IDX_WIDTH   region index taken from the registered address
//   onehot  out NUM_SLAVES  one-hot select (all zero on a miss)
//   hit     out 1           index < NUM_SLAVES
// ---------------------------------------------------------------------------
module apb_slave_decoder #(
  parameter int NUM_SLAVES = 4,
  parameter int IDX_WIDTH  = 2
) (
  input  logic [IDX_WIDTH-1:0]  index,
  output logic [NUM_SLAVES-1:0] onehot,
  output logic                  hit
);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block leaves it unassigned and a latch is never inferred.
  always_comb begin
    onehot = '0;
    hit    = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (index == IDX_WIDTH'(i)) begin
        onehot[i] = 1'b1;
        hit       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_apb_multi_bridge.sv
// ---------------------------------------------------------------------------
// ahb_apb_multi_bridge
// AHB-Lite subordinate that forwards each transfer to one of NUM_SLAVES APB
// completers. Each completer owns a 2**REGION_BITS byte region; the region
// index sits directly above the region offset in HADDR. Indices with no
// completer (NUM_SLAVES not a power of two) get a two-cycle ERROR response
// without any APB activity.
// Ports:
//   HCLK, HRESETn                 clock, async active-low reset
//   HSEL, HADDR, HTRANS, HWRITE,  AHB address phase
//   HREADY_IN, HWDATA             AHB bus ready, write data (data phase)
//   HRDATA, HRESP, HREADY_OUT     AHB response
//   PSEL, PENABLE, PADDR,         APB requester side
//   PWRITE, PWDATA
//   PRDATA, PREADY, PSLVERR       per-completer APB responses (packed)
// ---------------------------------------------------------------------------
module ahb_apb_multi_bridge
  import ahb_apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_SLAVES  = 4,
  parameter int REGION_BITS = 12
) (
  input  logic                           HCLK,
  input  logic                           HRESETn,
  input  logic                           HSEL,
  input  logic [ADDR_WIDTH-1:0]          HADDR,
  input  logic [1:0]                     HTRANS,
  input  logic                           HWRITE,
  input  logic                           HREADY_IN,
  input  logic [DATA_WIDTH-1:0]          HWDATA,
  output logic [DATA_WIDTH-1:0]          HRDATA,
  output logic [1:0]                     HRESP,
  output logic                           HREADY_OUT,
  output logic [NUM_SLAVES-1:0]          PSEL,
  output logic                           PENABLE,
  output logic [ADDR_WIDTH-1:0]          PADDR,
  output logic                           PWRITE,
  output logic [DATA_WIDTH-1:0]          PWDATA,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]          PREADY,
  input  logic [NUM_SLAVES-1:0]          PSLVERR
);

  localparam int IDX_WIDTH = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  bridge_state_e state, state_next;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [IDX_WIDTH-1:0]  idx_q;
  logic [IDX_WIDTH-1:0]  haddr_idx;

  logic [NUM_SLAVES-1:0] slave_onehot;
  logic                  slave_hit;
  logic                  sel_ready;
  logic                  sel_err;
  logic                  complete_ok;
  logic                  start;
  logic [DATA_WIDTH-1:0] rdata_sel;

  // Region index from the address phase; a single completer always decodes to 0.
  if (NUM_SLAVES == 1) begin : g_single
    assign haddr_idx = '0;
  end else begin : g_multi
    assign haddr_idx = HADDR[REGION_BITS +: IDX_WIDTH];
  end

  apb_slave_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_decoder (
    .index  (idx_q),
    .onehot (slave_onehot),
    .hit    (slave_hit)
  );

  // Only the selected completer's handshake and read data matter; masking with
  // the one-hot select avoids any out-of-range indexing.
  assign sel_ready = |(PREADY  & slave_onehot);
  assign sel_err   = |(PSLVERR & slave_onehot);

  always_comb begin
    rdata_sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (slave_onehot[i]) begin
        rdata_sel = rdata_sel | PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign complete_ok = (state == ST_ACCESS) && sel_ready && !sel_err;

  // A new address phase is taken whenever the bridge is, or is just becoming,
  // free: idle, second error cycle, or the OKAY-completing access cycle.
  assign start = HSEL && is_active_trans(HTRANS) && HREADY_IN &&
                 ((state == ST_IDLE) || (state == ST_ERR2) || complete_ok);

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values regardless of the order the blocks are evaluated in.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:   state_next = start ? ST_LATCH : ST_IDLE;
      ST_LATCH:  state_next = slave_hit ? ST_SETUP : ST_ERR1;
      ST_SETUP:  state_next = ST_ACCESS;
      ST_ACCESS: begin
        if (sel_ready) begin
          if (sel_err) state_next = ST_ERR1;
          else         state_next = start ? ST_LATCH : ST_IDLE;
        end
      end
      ST_ERR1:   state_next = ST_ERR2;
      ST_ERR2:   state_next = start ? ST_LATCH : ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    PSEL       = '0;
    PENABLE    = 1'b0;
    HREADY_OUT = 1'b0;
    HRESP      = HRESP_OKAY;
    HRDATA     = '0;
    unique case (state)
      ST_IDLE:   HREADY_OUT = 1'b1;
      ST_SETUP:  PSEL = slave_onehot;
      ST_ACCESS: begin
        PSEL       = slave_onehot;
        PENABLE    = 1'b1;
        HREADY_OUT = complete_ok;
        if (complete_ok && !write_q) HRDATA = rdata_sel;
      end
      ST_ERR1:   HRESP = HRESP_ERROR;
      ST_ERR2: begin
        HRESP      = HRESP_ERROR;
        HREADY_OUT = 1'b1;
      end
      default: ;
    endcase
  end

  // Address-phase capture and APB request registers. The APB fields load only
  // in LATCH, so they hold steady through SETUP/ACCESS and keep their last
  // values between transfers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      idx_q   <= '0;
      PADDR   <= '0;
      PWRITE  <= 1'b0;
      PWDATA  <= '0;
    end else begin
      if (start) begin
        addr_q  <= HADDR;
        write_q <= HWRITE;
        idx_q   <= haddr_idx;
      end
      if (state == ST_LATCH) begin
        PADDR  <= addr_q;
        PWRITE <= write_q;
        PWDATA <= HWDATA;
      end
    end
  end

endmodule

// File: tb/tb_ahb_apb_multi_bridge.sv
// ---------------------------------------------------------------------------
// tb_ahb_apb_multi_bridge
// Transaction-level bench: each AHB transfer is described by address, direction,
// data, number of APB wait cycles and completer error, and the expected bus
// behaviour is derived from the bridge's cycle rules (LATCH, SETUP, ACCESS...,
// optional two-cycle error). A second instance with three completers covers
// the unmapped-region error.
// ---------------------------------------------------------------------------
module tb_ahb_apb_multi_bridge;
  import ahb_apb_pkg::*;

  logic         HCLK = 1'b0;
  logic         HRESETn = 1'b0;
  logic         hsel = 1'b0;
  logic         hsel3 = 1'b0;
  logic [31:0]  haddr = '0;
  logic [1:0]   htrans = HTRANS_IDLE;
  logic         hwrite = 1'b0;
  logic         hready_in = 1'b1;
  logic [31:0]  hwdata = '0;

  logic [31:0]  hrdata;
  logic [1:0]   hresp;
  logic         hready_out;
  logic [3:0]   psel;
  logic         penable;
  logic [31:0]  paddr;
  logic         pwrite;
  logic [31:0]  pwdata;
  logic [127:0] prdata = '0;
  logic [3:0]   pready = '0;
  logic [3:0]   pslverr = '0;

  logic [31:0]  hrdata3;
  logic [1:0]   hresp3;
  logic         hready3;
  logic [2:0]   psel3;
  logic         penable3;
  logic [31:0]  paddr3;
  logic         pwrite3;
  logic [31:0]  pwdata3;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] cur_addr;
  logic        cur_wr;
  logic [31:0] force_rd = '0;

  always #5 HCLK = ~HCLK;

  ahb_apb_multi_bridge #(.NUM_SLAVES(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HREADY_IN(hready_in), .HWDATA(hwdata), .HRDATA(hrdata),
    .HRESP(hresp), .HREADY_OUT(hready_out), .PSEL(psel), .PENABLE(penable),
    .PADDR(paddr), .PWRITE(pwrite), .PWDATA(pwdata), .PRDATA(prdata),
    .PREADY(pready), .PSLVERR(pslverr)
  );

  ahb_apb_multi_bridge #(.NUM_SLAVES(3)) dut3 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel3), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HREADY_IN(hready_in), .HWDATA(hwdata), .HRDATA(hrdata3),
    .HRESP(hresp3), .HREADY_OUT(hready3), .PSEL(psel3), .PENABLE(penable3),
    .PADDR(paddr3), .PWRITE(pwrite3), .PWDATA(pwdata3),
    .PRDATA({32'hCCCC_0002, 32'hCCCC_0001, 32'hCCCC_0000}),
    .PREADY(3'b111), .PSLVERR(3'b000)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge HCLK);
    #1;
  endtask

  // Issue an address phase while the bridge is idle, checking idle outputs.
  task automatic start_xfer(input logic [31:0] addr, input logic wr);
    hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = addr; hwrite = wr;
    cur_addr = addr; cur_wr = wr;
    @(negedge HCLK);
    check("idle_hready", {31'b0, hready_out}, 32'd1);
    check("idle_psel", {28'b0, psel}, 32'd0);
    check("idle_penable", {31'b0, penable}, 32'd0);
    check("idle_hresp", {30'b0, hresp}, 32'd0);
    next_cycle();
  endtask

  // Drive the follow-up address phase: 0 none, 1 NONSEQ, 2 BUSY.
  task automatic drive_next(input int kind, input logic [31:0] addr, input logic wr);
    if (kind == 1) begin
      hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = addr; hwrite = wr;
    end else if (kind == 2) begin
      hsel = 1'b1; htrans = HTRANS_BUSY; haddr = addr; hwrite = wr;
    end else begin
      hsel = 1'b0; htrans = HTRANS_IDLE;
    end
  endtask

  // Data phase of the current transfer, starting in its LATCH cycle.
  task automatic data_phase(input logic [31:0] wdata, input int waits, input bit slverr,
                            input int nxt_kind, input logic [31:0] nxt_addr, input logic nxt_wr);
    int          idx;
    logic [3:0]  onehot;
    logic [31:0] slice [4];
    logic [31:0] exp_rd;
    bit          last;
    idx    = int'(cur_addr[13:12]);
    onehot = 4'b0001 << idx;

    hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = wdata;
    @(negedge HCLK);
    check("latch_hready", {31'b0, hready_out}, 32'd0);
    check("latch_psel", {28'b0, psel}, 32'd0);
    next_cycle();

    hwdata = $urandom;
    @(negedge HCLK);
    check("setup_psel", {28'b0, psel}, {28'b0, onehot});
    check("setup_penable", {31'b0, penable}, 32'd0);
    check("setup_paddr", paddr, cur_addr);
    check("setup_pwrite", {31'b0, pwrite}, {31'b0, cur_wr});
    check("setup_pwdata", pwdata, wdata);
    check("setup_hready", {31'b0, hready_out}, 32'd0);
    next_cycle();

    for (int w = 0; w <= waits; w++) begin
      last = (w == waits);
      for (int s = 0; s < 4; s++) slice[s] = $urandom;
      if (force_rd != 0) slice[idx] = force_rd;
      prdata  = {slice[3], slice[2], slice[1], slice[0]};
      pready  = 4'($urandom);
      pslverr = 4'($urandom);
      pready[idx]  = last;
      pslverr[idx] = last ? slverr : 1'($urandom);
      if (last && !slverr) drive_next(nxt_kind, nxt_addr, nxt_wr);
      exp_rd = (last && !slverr && !cur_wr) ? slice[idx] : 32'd0;
      @(negedge HCLK);
      check("access_psel", {28'b0, psel}, {28'b0, onehot});
      check("access_penable", {31'b0, penable}, 32'd1);
      check("access_paddr", paddr, cur_addr);
      check("access_pwdata", pwdata, wdata);
      check("access_hready", {31'b0, hready_out}, {31'b0, last && !slverr});
      check("access_hresp", {30'b0, hresp}, 32'd0);
      check("access_hrdata", hrdata, exp_rd);
      next_cycle();
    end
    pready = '0; pslverr = '0;

    if (slverr) begin
      @(negedge HCLK);
      check("err1_hresp", {30'b0, hresp}, {30'b0, HRESP_ERROR});
      check("err1_hready", {31'b0, hready_out}, 32'd0);
      check("err1_psel", {28'b0, psel}, 32'd0);
      next_cycle();
      drive_next(nxt_kind, nxt_addr, nxt_wr);
      @(negedge HCLK);
      check("err2_hresp", {30'b0, hresp}, {30'b0, HRESP_ERROR});
      check("err2_hready", {31'b0, hready_out}, 32'd1);
      check("err2_psel", {28'b0, psel}, 32'd0);
      next_cycle();
    end

    if (nxt_kind == 1) begin
      cur_addr = nxt_addr; cur_wr = nxt_wr;
    end else begin
      hsel = 1'b0; htrans = HTRANS_IDLE;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          chained;
    int          kind;
    logic [31:0] na;
    logic        nw;

    // Reset state.
    repeat (2) @(posedge HCLK);
    #1;
    check("rst_hready", {31'b0, hready_out}, 32'd1);
    check("rst_hresp", {30'b0, hresp}, 32'd0);
    check("rst_psel", {28'b0, psel}, 32'd0);
    check("rst_pwdata", pwdata, 32'd0);
    HRESETn = 1'b1;

    // Write to completer 1, no waits; acceptance on the first edge after reset.
    start_xfer(32'h0000_1004, 1'b1);
    data_phase(32'hDEAD_BEEF, 0, 1'b0, 0, '0, 1'b0);

    // Read from completer 3 with two wait cycles.
    force_rd = 32'h1234_5678;
    start_xfer(32'h0000_3000, 1'b0);
    data_phase(32'h0, 2, 1'b0, 0, '0, 1'b0);
    force_rd = '0;

    // Completer error on completer 2.
    start_xfer(32'h0000_2000, 1'b1);
    data_phase(32'hA5A5_5A5A, 1, 1'b1, 0, '0, 1'b0);

    // Back-to-back NONSEQ, then a BUSY that must be ignored.
    start_xfer(32'h0000_0010, 1'b0);
    data_phase(32'h0, 0, 1'b0, 1, 32'h0000_1008, 1'b1);
    data_phase(32'h0BAD_F00D, 1, 1'b0, 2, 32'h0000_2000, 1'b0);
    start_xfer(32'h0000_2040, 1'b1);
    data_phase(32'h1357_9BDF, 0, 1'b0, 0, '0, 1'b0);

    // Reset asserted in the middle of an ACCESS wait cycle.
    start_xfer(32'h0000_3010, 1'b1);
    hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'hFFFF_0000;
    next_cycle();
    next_cycle();
    pready = '0;
    #2;
    HRESETn = 1'b0;
    #1;
    check("mid_rst_psel", {28'b0, psel}, 32'd0);
    check("mid_rst_penable", {31'b0, penable}, 32'd0);
    check("mid_rst_paddr", paddr, 32'd0);
    check("mid_rst_pwrite", {31'b0, pwrite}, 32'd0);
    check("mid_rst_pwdata", pwdata, 32'd0);
    check("mid_rst_hready", {31'b0, hready_out}, 32'd1);
    check("mid_rst_hresp", {30'b0, hresp}, 32'd0);
    check("mid_rst_hrdata", hrdata, 32'd0);
    next_cycle();
    HRESETn = 1'b1;
    start_xfer(32'h0000_0020, 1'b0);
    data_phase(32'h0, 1, 1'b0, 0, '0, 1'b0);

    // Randomised traffic, mixing isolated, chained and BUSY-followed transfers.
    chained = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!chained) start_xfer($urandom, 1'($urandom));
      kind = int'($urandom_range(0, 2));
      na   = $urandom;
      nw   = 1'($urandom);
      data_phase($urandom, int'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0),
                 kind, na, nw);
      chained = (kind == 1);
    end
    if (chained) data_phase($urandom, 0, 1'b0, 0, '0, 1'b0);

    // Three-completer instance: region 3 is unmapped, region 2 is real.
    hsel3 = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h0000_3000; hwrite = 1'b0;
    @(negedge HCLK);
    check("n3_idle_hready", {31'b0, hready3}, 32'd1);
    next_cycle();
    hsel3 = 1'b0; htrans = HTRANS_IDLE;
    @(negedge HCLK);
    check("n3_latch_hready", {31'b0, hready3}, 32'd0);
    check("n3_latch_psel", {29'b0, psel3}, 32'd0);
    next_cycle();
    @(negedge HCLK);
    check("n3_err1_hresp", {30'b0, hresp3}, {30'b0, HRESP_ERROR});
    check("n3_err1_hready", {31'b0, hready3}, 32'd0);
    check("n3_err1_psel", {29'b0, psel3}, 32'd0);
    next_cycle();
    @(negedge HCLK);
    check("n3_err2_hresp", {30'b0, hresp3}, {30'b0, HRESP_ERROR});
    check("n3_err2_hready", {31'b0, hready3}, 32'd1);
    check("n3_err2_psel", {29'b0, psel3}, 32'd0);
    next_cycle();
    hsel3 = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h0000_2004; hwrite = 1'b0;
    @(negedge HCLK);
    check("n3_idle_hresp", {30'b0, hresp3}, 32'd0);
    next_cycle();
    hsel3 = 1'b0; htrans = HTRANS_IDLE;
    next_cycle();
    @(negedge HCLK);
    check("n3_setup_psel", {29'b0, psel3}, 32'd4);
    next_cycle();
    @(negedge HCLK);
    check("n3_access_hready", {31'b0, hready3}, 32'd1);
    check("n3_access_hrdata", hrdata3, 32'hCCCC_0002);
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
